// File: rtl/bcd_to_score.sv
// Sequential BCD-to-binary score converter: one digit per clock, MSD first, via acc*10+digit.
// Overflow handling selected by BCD_TO_SCORE_SATURATE_EN (defined: clamp to max, undefined: modulo wrap).
module bcd_to_score #(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 13
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    Start,
  input  logic [4*NUM_DIGITS-1:0] Digits,
  output logic [SCORE_W-1:0]      Score,
  output logic                    Valid,
  output logic                    Busy,
  output logic                    Error,
  output logic                    Overflow
);

  localparam int ACC_W = SCORE_W + 4;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    inv_q, inv_d;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic                    err_q, err_d;
  logic                    ovf_q, ovf_d;
  logic                    valid_q, valid_d;

  logic [3:0]              cur_digit;
  logic [ACC_W-1:0]        acc_mac;
  logic                    in_invalid;

  assign cur_digit = digits_q[{idx_q, 2'b00} +: 4];
  assign acc_mac   = (acc_q << 3) + (acc_q << 1) + {{(ACC_W-4){1'b0}}, cur_digit};

  always_comb begin
    in_invalid = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (Digits[4*i +: 4] > 4'd9) in_invalid = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    inv_d    = inv_q;
    score_d  = score_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          digits_d = Digits;
          acc_d    = '0;
          idx_d    = IDX_W'(NUM_DIGITS - 1);
          inv_d    = in_invalid;
          state_d  = S_CONV;
        end
      end
      S_CONV: begin
        acc_d = acc_mac;
        if (idx_q == '0) begin
          // Result is registered on the same edge that enters DONE.
          state_d = S_DONE;
          valid_d = 1'b1;
          if (inv_q) begin
            score_d = '0;
            err_d   = 1'b1;
            ovf_d   = 1'b0;
          end else if (|acc_mac[ACC_W-1:SCORE_W]) begin
            err_d = 1'b0;
            ovf_d = 1'b1;
`ifdef BCD_TO_SCORE_SATURATE_EN
            score_d = '1;
`else
            score_d = acc_mac[SCORE_W-1:0];
`endif
          end else begin
            score_d = acc_mac[SCORE_W-1:0];
            err_d   = 1'b0;
            ovf_d   = 1'b0;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      digits_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      inv_q    <= 1'b0;
      score_q  <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      inv_q    <= inv_d;
      score_q  <= score_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign Score    = score_q;
  assign Valid    = valid_q;
  assign Busy     = (state_q != S_IDLE);
  assign Error    = err_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_bcd_to_score.sv
// Scoreboard bench for bcd_to_score: stimulus pushes expected results, a negedge monitor pops on Valid.
module tb_bcd_to_score;

  localparam int ND = 4;
  localparam int SW = 13;
`ifdef BCD_TO_SCORE_SATURATE_EN
  localparam int OVF_SCORE = 8191;
`else
  localparam int OVF_SCORE = 1807;
`endif

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Start = 1'b0;
  logic [4*ND-1:0] Digits = '0;
  logic [SW-1:0] Score;
  logic          Valid, Busy, Error, Overflow;

  bcd_to_score #(.NUM_DIGITS(ND), .SCORE_W(SW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Digits(Digits),
    .Score(Score), .Valid(Valid), .Busy(Busy), .Error(Error), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  typedef struct { int score; int err; int ovf; int cyc; } exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Valid must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got Valid=1 with Score=%0d, expected no Valid (cycle %0d)", Score, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("score", int'(Score), e.score);
        chk("error", int'(Error), e.err);
        chk("overflow", int'(Overflow), e.ovf);
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_done();
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge Clk);
      if (sb.size() == 0) break;
    end
    if (k == 60) chk("drain_timeout", sb.size(), 0);
    @(negedge Clk);
  endtask

  task automatic issue(input logic [15:0] bcd, input int score, input int err, input int ovf);
    exp_t e;
    @(negedge Clk);
    Digits  = bcd;
    Start   = 1'b1;
    e.score = score; e.err = err; e.ovf = ovf; e.cyc = cyc + 1 + ND;
    sb.push_back(e);
    @(negedge Clk);
    Start   = 1'b0;
    Digits  = 16'hFFFF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_score", int'(Score), 0);
    chk("rst_valid", int'(Valid), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_error", int'(Error), 0);
    chk("rst_overflow", int'(Overflow), 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // 1234 with Busy profile: high for 5 cycles after accept
    begin
      exp_t e;
      Digits = 16'h1234;
      Start  = 1'b1;
      e.score = 1234; e.err = 0; e.ovf = 0; e.cyc = cyc + 1 + ND;
      sb.push_back(e);
      for (int i = 0; i < 6; i++) begin
        @(negedge Clk);
        Start  = 1'b0;
        Digits = 16'h9876;
        chk("busy_profile", int'(Busy), (i < 5) ? 1 : 0);
      end
    end
    wait_done();

    issue(16'h8191, 8191, 0, 0);      wait_done();
    issue(16'h0000, 0, 0, 0);         wait_done();
    issue(16'h9999, OVF_SCORE, 0, 1); wait_done();
    issue(16'h12A4, 0, 1, 0);         wait_done();
    issue(16'h0999, 999, 0, 0);       wait_done();
    issue(16'h8192, OVF_SCORE == 8191 ? 8191 : 0, 0, 1); wait_done();

    // Start held 20 cycles, Digits = 2000+j at edge j; accepts every 6 edges
    @(negedge Clk);
    Start = 1'b1;
    for (int j = 0; j < 20; j++) begin
      Digits = {4'h2, 4'h0, 4'(j / 10), 4'(j % 10)};
      if (j % 6 == 0) begin
        exp_t e;
        e.score = 2000 + j; e.err = 0; e.ovf = 0; e.cyc = cyc + 1 + ND;
        sb.push_back(e);
      end
      @(negedge Clk);
    end
    Start = 1'b0;
    wait_done();

    // Reset during the second CONV cycle aborts with no Valid
    @(negedge Clk);
    Digits = 16'h5678;
    Start  = 1'b1;
    @(negedge Clk);
    Start  = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    chk("abort_score", int'(Score), 0);
    chk("abort_valid", int'(Valid), 0);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_error", int'(Error), 0);
    chk("abort_overflow", int'(Overflow), 0);
    repeat (10) @(negedge Clk);

    issue(16'h0042, 42, 0, 0); wait_done();
    repeat (4) @(negedge Clk);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_score.md
Name: bcd_to_score

Overview:
- Sequential BCD-to-binary converter: the inverse of the score-to-digit display path.
- Takes a four-digit packed BCD value (player-entered target or stored high score, one nibble per seven-seg position) and produces the 13-bit binary score used by the game logic.
- Multiply-by-10-and-add, one digit per clock, most significant digit first.
- Valid/Start handshake with busy, invalid-digit and overflow flags.

Parameters:
- NUM_DIGITS, 4: BCD digits converted per request; supported range 2..4.
- SCORE_W, 13: binary score width; max representable value 2^SCORE_W-1 (8191).

Ports:
- Clk, input, 1: system clock; all state updates on rising edge.
- Reset_n, input, 1: synchronous active-low reset, sampled on the Clk rising edge.
- Start, input, 1: request conversion; accepted only in IDLE.
- Digits, input, 4*NUM_DIGITS: packed BCD. [3:0] is the ones digit (Screen1 position); the top nibble is the most significant.
- Score, output, SCORE_W: registered binary result; held until the next completion.
- Valid, output, 1: one-cycle pulse; Score, Error and Overflow are fresh.
- Busy, output, 1: high in CONV and DONE; Start is ignored while high.
- Error, output, 1: at least one latched nibble was greater than 9.
- Overflow, output, 1: the decimal value exceeds 2^SCORE_W-1.

Behaviour:
- Reset (Reset_n low at an edge):
  - State goes to IDLE.
  - Score=0, Valid=0, Busy=0, Error=0, Overflow=0.
  - Internal accumulator and digit index are cleared.
  - Aborts any conversion in progress; no Valid is issued for it.
- States: IDLE, CONV, DONE.
- IDLE:
  - Edge with Start=1: latch Digits into a shadow register; acc=0; idx=NUM_DIGITS-1.
  - Compute the invalid flag (any nibble >9) from the latched digits and hold it; go to CONV.
  - Start=0: stay in IDLE.
- CONV, each edge:
  - acc = acc*10 + digit[idx], computed as (acc<<3)+(acc<<1)+digit.
  - Accumulator is SCORE_W+4 bits wide, so it never wraps (9999 fits).
  - If idx==0, go to DONE; else idx=idx-1.
  - CONV lasts exactly NUM_DIGITS cycles.
- DONE, on entry edge:
  - Score, Error and Overflow are registered.
  - Valid=1 for exactly one cycle; next edge returns to IDLE.
- Result rules:
  - Invalid flag set: Score=0, Error=1, Overflow=0.
  - Else if acc > 2^SCORE_W-1: Overflow=1; Score value per the optional feature.
  - Else: Score=acc, Error=0, Overflow=0.
- Latency: Start sampled at edge E0 gives Valid high after edge E(NUM_DIGITS+1)-1, i.e. 4 cycles after the Start edge for NUM_DIGITS=4.
- Throughput: the earliest next accept is the edge after DONE, one request per NUM_DIGITS+2 cycles.
- Changes to Digits after the accept edge have no effect on the current conversion.
- Start held high continuously causes back-to-back conversions at the maximum rate.
- Start together with reset: reset wins.
- Error and Overflow are valid alongside Valid and hold their value until the next DONE.

Optional Feature:
- Macro: BCD_TO_SCORE_SATURATE_EN.
- Defined: on overflow, Score = 2^SCORE_W-1 (8191); Overflow=1.
- Undefined: on overflow, Score = acc[SCORE_W-1:0] (modulo wrap, 9999 gives 1807); Overflow=1.
- All other behaviour is identical in both builds.

Test Plan:
- Digits=16'h1234, Start for 1 cycle -> Busy for 5 cycles; Valid pulses 4 cycles after the Start edge; Score=1234 (13'h04D2); Error=0; Overflow=0.
- Digits=16'h8191 -> Score=8191, Overflow=0. Then 16'h0000 -> Score=0, Valid, no flags.
- Digits=16'h9999 -> Overflow=1. Score=8191 with BCD_TO_SCORE_SATURATE_EN defined; Score=1807 without it.
- Digits=16'h12A4 -> Error=1, Score=0, Overflow=0, same latency.
- Start held high for 20 cycles with Digits changed every cycle:
  - Each conversion uses the digits latched at its own accept edge.
  - Valid pulses are spaced 6 cycles apart.
  - Start is ignored while Busy=1.
- Reset_n low for 1 cycle during the second CONV cycle -> next edge has all outputs 0, state IDLE, no Valid. A new Start with 16'h0042 gives Score=42.
